// File: rtl/clock_group_reset_sequencer.sv
// Reset and clock-gating sequencer for one clock group.
// After group reset all member resets are held, then released one member at a
// time. In RUN the group can be quiesced and its member clocks gated on request,
// and re-enabled with a settle period on wake.
// Optional feature macro: CLOCK_GROUP_SEQ_TIMEOUT_EN (aborts a QUIESCE that
// never completes and pulses quiesce_timeout).
module clock_group_reset_sequencer #(
  parameter int unsigned NUM_MEMBERS    = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  input  logic                   gate_req,
  input  logic [NUM_MEMBERS-1:0] member_idle,
  output logic [NUM_MEMBERS-1:0] member_reset,
  output logic [NUM_MEMBERS-1:0] member_clock_en,
  output logic                   quiesce_req,
  output logic                   ready,
  output logic                   gated,
  output logic                   quiesce_timeout
);

  localparam int unsigned IdxW = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;

  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] StaggerLast = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast     = IdxW'(NUM_MEMBERS - 1);

  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StRun,
    StQuiesce,
    StGated,
    StWake
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   streak_q, streak_d;
  logic                   release_fire;

  logic [NUM_MEMBERS-1:0] member_reset_q, member_reset_d;
  logic [NUM_MEMBERS-1:0] member_clock_en_q, member_clock_en_d;
  logic                   quiesce_req_q, quiesce_req_d;
  logic                   ready_q, ready_d;
  logic                   gated_q, gated_d;

  logic all_idle;
  assign all_idle = &member_idle;

`ifdef CLOCK_GROUP_SEQ_TIMEOUT_EN
  // Last counter value of a QUIESCE dwell of 2^CNT_W-1 cycles.
  localparam logic [CNT_W-1:0] TimeoutLast = {{(CNT_W-1){1'b1}}, 1'b0};

  logic timeout_fire;
  logic timeout_q;
  logic armed_q, armed_d;

  // Re-arm the gate request only once gate_req has been seen low after a timeout.
  always_comb begin
    armed_d = armed_q;
    if (sw_reset_req || !gate_req) begin
      armed_d = 1'b1;
    end else if (timeout_fire) begin
      armed_d = 1'b0;
    end
  end

  // Timeout pulse register and re-arm flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      timeout_q <= timeout_fire;
      armed_q   <= armed_d;
    end
  end

  assign quiesce_timeout = timeout_q;
`else
  assign quiesce_timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= StHold;
      cnt_q             <= '0;
      idx_q             <= '0;
      streak_q          <= 1'b0;
      member_reset_q    <= '1;
      member_clock_en_q <= '1;
      quiesce_req_q     <= 1'b0;
      ready_q           <= 1'b0;
      gated_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      idx_q             <= idx_d;
      streak_q          <= streak_d;
      member_reset_q    <= member_reset_d;
      member_clock_en_q <= member_clock_en_d;
      quiesce_req_q     <= quiesce_req_d;
      ready_q           <= ready_d;
      gated_q           <= gated_d;
    end
  end

  // Next state, counter, member index and idle streak.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    streak_d     = streak_q;
    release_fire = 1'b0;
`ifdef CLOCK_GROUP_SEQ_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    if (sw_reset_req) begin
      state_d  = StHold;
      cnt_d    = '0;
      idx_d    = '0;
      streak_d = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_d   = '0;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == StaggerLast) begin
            release_fire = 1'b1;
            cnt_d        = '0;
            if (idx_q == IdxLast) begin
              state_d = StRun;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
`ifdef CLOCK_GROUP_SEQ_TIMEOUT_EN
          if (gate_req && armed_q) begin
`else
          if (gate_req) begin
`endif
            state_d  = StQuiesce;
            cnt_d    = '0;
            streak_d = 1'b0;
          end
        end
        StQuiesce: begin
          // Dropping the request wins over completing the gate on the same edge.
          if (!gate_req) begin
            state_d = StRun;
          end else if (all_idle && streak_q) begin
            state_d = StGated;
          end else begin
            streak_d = all_idle;
`ifdef CLOCK_GROUP_SEQ_TIMEOUT_EN
            if (cnt_q == TimeoutLast) begin
              timeout_fire = 1'b1;
              state_d      = StRun;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`endif
          end
        end
        StGated: begin
          if (!gate_req) begin
            state_d = StWake;
            cnt_d   = '0;
          end
        end
        StWake: begin
          if (cnt_q == StaggerLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StHold;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output next values derived from the state being entered.
  always_comb begin
    member_reset_d = member_reset_q;
    if (state_d == StHold) begin
      member_reset_d = '1;
    end else if (release_fire) begin
      member_reset_d[idx_q] = 1'b0;
    end
    // Clocks only stop in GATED, which is unreachable while any reset is held.
    member_clock_en_d = (state_d == StGated) ? '0 : '1;
    quiesce_req_d     = (state_d == StQuiesce) || (state_d == StGated) || (state_d == StWake);
    ready_d           = (state_d == StRun);
    gated_d           = (state_d == StGated);
  end

  assign member_reset    = member_reset_q;
  assign member_clock_en = member_clock_en_q;
  assign quiesce_req     = quiesce_req_q;
  assign ready           = ready_q;
  assign gated           = gated_q;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed testbench for clock_group_reset_sequencer at default parameters.
module tb_clock_group_reset_sequencer;

  localparam int N     = 4;
  localparam int HOLD  = 16;
  localparam int STAG  = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         sw_reset_req = 1'b0;
  logic         gate_req = 1'b0;
  logic [N-1:0] member_idle = '0;
  logic [N-1:0] member_reset;
  logic [N-1:0] member_clock_en;
  logic         quiesce_req;
  logic         ready;
  logic         gated;
  logic         quiesce_timeout;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_rst;
  logic         got_ready;

  clock_group_reset_sequencer #(
    .NUM_MEMBERS   (N),
    .HOLD_CYCLES   (HOLD),
    .STAGGER_CYCLES(STAG),
    .CNT_W         (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sw_reset_req   (sw_reset_req),
    .gate_req       (gate_req),
    .member_idle    (member_idle),
    .member_reset   (member_reset),
    .member_clock_en(member_clock_en),
    .quiesce_req    (quiesce_req),
    .ready          (ready),
    .gated          (gated),
    .quiesce_timeout(quiesce_timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for ready; reports whether it was seen.
  task automatic wait_ready(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (ready === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({member_reset, member_clock_en, quiesce_req, ready, gated, quiesce_timeout} !==
        {4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rst=%b en=%b q=%b r=%b g=%b t=%b want 1111 1111 0 0 0 0",
               member_reset, member_clock_en, quiesce_req, ready, gated, quiesce_timeout);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_release();
    for (int e = 1; e <= 32; e++) begin
      step();
      for (int i = 0; i < N; i++) exp_rst[i] = (e >= HOLD + (i + 1) * STAG) ? 1'b0 : 1'b1;
      checks++;
      if ({member_reset, member_clock_en, ready, quiesce_req, gated} !==
          {exp_rst, 4'b1111, (e >= 32), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL release_edge%0d: got rst=%b en=%b r=%b q=%b g=%b want rst=%b en=1111 r=%b",
                 e, member_reset, member_clock_en, ready, quiesce_req, gated, exp_rst, e >= 32);
      end
    end
  endtask

  task automatic test_gate_wake();
    gate_req = 1'b1;
    member_idle = 4'b1111;
    step();
    checks++;
    if ({quiesce_req, ready, gated, member_clock_en} !== {1'b1, 1'b0, 1'b0, 4'b1111}) begin
      errors++;
      $display("FAIL gate_plus1: got q=%b r=%b g=%b en=%b want 1 0 0 1111",
               quiesce_req, ready, gated, member_clock_en);
    end
    step();
    checks++;
    if ({gated, member_clock_en} !== {1'b0, 4'b1111}) begin
      errors++;
      $display("FAIL gate_plus2: got g=%b en=%b want 0 1111", gated, member_clock_en);
    end
    step();
    checks++;
    if ({gated, member_clock_en, quiesce_req, quiesce_timeout} !== {1'b1, 4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL gate_plus3: got g=%b en=%b q=%b t=%b want 1 0000 1 0",
               gated, member_clock_en, quiesce_req, quiesce_timeout);
    end
    gate_req = 1'b0;
    step();
    checks++;
    if ({gated, member_clock_en, quiesce_req, ready} !== {1'b0, 4'b1111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wake_plus1: got g=%b en=%b q=%b r=%b want 0 1111 1 0",
               gated, member_clock_en, quiesce_req, ready);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      checks++;
      if ({quiesce_req, ready} !== {(k < 5), (k >= 5)}) begin
        errors++;
        $display("FAIL wake_plus%0d: got q=%b r=%b want q=%b r=%b",
                 k, quiesce_req, ready, k < 5, k >= 5);
      end
    end
  endtask

  task automatic test_idle_streak();
    gate_req = 1'b1;
    member_idle = 4'b0111;
    step();
    for (int k = 0; k < 8; k++) begin
      member_idle = (k % 2 == 0) ? 4'b1111 : 4'b0111;
      step();
      checks++;
      if ({gated, quiesce_req} !== 2'b01) begin
        errors++;
        $display("FAIL toggle_idle%0d: got g=%b q=%b want 0 1", k, gated, quiesce_req);
      end
    end
    member_idle = 4'b1111;
    step();
    checks++;
    if (gated !== 1'b0) begin
      errors++;
      $display("FAIL streak_first: got g=%b want 0", gated);
    end
    step();
    checks++;
    if ({gated, member_clock_en} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL streak_second: got g=%b en=%b want 1 0000", gated, member_clock_en);
    end
    gate_req = 1'b0;
    wait_ready(got_ready);
    checks++;
    if (got_ready !== 1'b1) begin
      errors++;
      $display("FAIL streak_wake: got ready_seen=%b want 1", got_ready);
    end
  endtask

  task automatic test_abort();
    gate_req = 1'b1;
    member_idle = 4'b0000;
    step();
    step();
    step();
    checks++;
    if ({quiesce_req, ready, gated} !== 3'b100) begin
      errors++;
      $display("FAIL abort_wait: got q=%b r=%b g=%b want 1 0 0", quiesce_req, ready, gated);
    end
    gate_req = 1'b0;
    step();
    checks++;
    if ({quiesce_req, ready, gated, member_clock_en} !== {3'b010, 4'b1111}) begin
      errors++;
      $display("FAIL abort_run: got q=%b r=%b g=%b en=%b want 0 1 0 1111",
               quiesce_req, ready, gated, member_clock_en);
    end
  endtask

  task automatic test_sw_reset_mid_release();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    gate_req = 1'b1;  // must be ignored while the release sequence runs
    checks++;
    if ({member_reset, ready} !== {4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL sw_from_run: got rst=%b r=%b want 1111 0", member_reset, ready);
    end
    for (int e = 1; e <= 24; e++) step();
    checks++;
    if (member_reset !== 4'b1100) begin
      errors++;
      $display("FAIL sw_mid_point: got rst=%b want 1100", member_reset);
    end
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    checks++;
    if (member_reset !== 4'b1111) begin
      errors++;
      $display("FAIL sw_mid_release: got rst=%b want 1111", member_reset);
    end
    for (int e = 1; e <= 32; e++) begin
      step();
      for (int i = 0; i < N; i++) exp_rst[i] = (e >= HOLD + (i + 1) * STAG) ? 1'b0 : 1'b1;
      checks++;
      if ({member_reset, ready, quiesce_req} !== {exp_rst, (e >= 32), 1'b0}) begin
        errors++;
        $display("FAIL restart_edge%0d: got rst=%b r=%b q=%b want rst=%b r=%b q=0",
                 e, member_reset, ready, quiesce_req, exp_rst, e >= 32);
      end
    end
    gate_req = 1'b0;
  endtask

  task automatic test_sw_priority();
    sw_reset_req = 1'b1;
    gate_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({member_reset, member_clock_en, quiesce_req, ready} !== {8'hFF, 2'b00}) begin
        errors++;
        $display("FAIL sw_hold%0d: got rst=%b en=%b q=%b r=%b want 1111 1111 0 0",
                 k, member_reset, member_clock_en, quiesce_req, ready);
      end
    end
    sw_reset_req = 1'b0;
    gate_req = 1'b0;
    for (int e = 1; e <= 19; e++) step();
    checks++;
    if (member_reset[0] !== 1'b1) begin
      errors++;
      $display("FAIL sw_held_edge19: got rst0=%b want 1", member_reset[0]);
    end
    step();
    checks++;
    if (member_reset[0] !== 1'b0) begin
      errors++;
      $display("FAIL sw_held_edge20: got rst0=%b want 0", member_reset[0]);
    end
    wait_ready(got_ready);
    // Software reset from GATED must restore clocks together with resets.
    gate_req = 1'b1;
    member_idle = 4'b1111;
    step();
    step();
    step();
    checks++;
    if (gated !== 1'b1) begin
      errors++;
      $display("FAIL pre_sw_gated: got g=%b want 1", gated);
    end
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    gate_req = 1'b0;
    checks++;
    if ({member_reset, member_clock_en, gated, quiesce_req} !== {8'hFF, 2'b00}) begin
      errors++;
      $display("FAIL sw_from_gated: got rst=%b en=%b g=%b q=%b want 1111 1111 0 0",
               member_reset, member_clock_en, gated, quiesce_req);
    end
    wait_ready(got_ready);
    checks++;
    if (got_ready !== 1'b1) begin
      errors++;
      $display("FAIL sw_recover: got ready_seen=%b want 1", got_ready);
    end
  endtask

`ifdef CLOCK_GROUP_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    gate_req = 1'b1;
    member_idle = 4'b0000;
    step();
    for (int k = 1; k <= 254; k++) begin
      step();
      checks++;
      if ({quiesce_timeout, quiesce_req} !== 2'b01) begin
        errors++;
        $display("FAIL tmo_dwell%0d: got t=%b q=%b want 0 1", k, quiesce_timeout, quiesce_req);
      end
    end
    step();
    checks++;
    if ({quiesce_timeout, quiesce_req, ready} !== 3'b101) begin
      errors++;
      $display("FAIL tmo_fire: got t=%b q=%b r=%b want 1 0 1", quiesce_timeout, quiesce_req, ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({quiesce_timeout, quiesce_req, ready} !== 3'b001) begin
        errors++;
        $display("FAIL tmo_blocked%0d: got t=%b q=%b r=%b want 0 0 1",
                 k, quiesce_timeout, quiesce_req, ready);
      end
    end
    gate_req = 1'b0;
    step();
    gate_req = 1'b1;
    step();
    checks++;
    if (quiesce_req !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rearm: got q=%b want 1", quiesce_req);
    end
    gate_req = 1'b0;
    step();
  endtask
`endif

  task automatic test_async_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({member_reset, member_clock_en, quiesce_req, ready, gated} !== {8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: got rst=%b en=%b q=%b r=%b g=%b want 1111 1111 0 0 0",
               member_reset, member_clock_en, quiesce_req, ready, gated);
    end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_gate_wake();
    test_idle_streak();
    test_abort();
    test_sw_reset_mid_release();
    test_sw_priority();
`ifdef CLOCK_GROUP_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
